// File: rtl/query_sort_ctrl.sv
// Per-query controller that streams candidates into an external 4-deep sorted list
// and returns the captured nearest-neighbour result through a valid/ready handshake.
module query_sort_ctrl #(
    parameter int DIST_W = 25,
    parameter int IDX_W  = 15,
    parameter int CNT_W  = 10,
    parameter int QID_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              q_valid,
    output logic              q_ready,
    input  logic [QID_W-1:0]  q_id,
    input  logic [CNT_W-1:0]  q_num_cand,
    input  logic              c_valid,
    output logic              c_ready,
    input  logic [DIST_W-1:0] c_dist,
    input  logic [IDX_W-1:0]  c_idx,
    output logic              sl_insert,
    output logic              sl_restart,
    output logic              sl_last,
    output logic [DIST_W-1:0] sl_dist,
    output logic [IDX_W-1:0]  sl_idx,
    input  logic              sl_valid_out,
    input  logic [DIST_W-1:0] sl_dist_0,
    input  logic [DIST_W-1:0] sl_dist_1,
    input  logic [DIST_W-1:0] sl_dist_2,
    input  logic [DIST_W-1:0] sl_dist_3,
    input  logic [IDX_W-1:0]  sl_idx_0,
    input  logic [IDX_W-1:0]  sl_idx_1,
    input  logic [IDX_W-1:0]  sl_idx_2,
    input  logic [IDX_W-1:0]  sl_idx_3,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [QID_W-1:0]  r_id,
    output logic [2:0]        r_count,
    output logic [DIST_W-1:0] r_dist_0,
    output logic [DIST_W-1:0] r_dist_1,
    output logic [DIST_W-1:0] r_dist_2,
    output logic [DIST_W-1:0] r_dist_3,
    output logic [IDX_W-1:0]  r_idx_0,
    output logic [IDX_W-1:0]  r_idx_1,
    output logic [IDX_W-1:0]  r_idx_2,
    output logic [IDX_W-1:0]  r_idx_3,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, STREAM, EMPTY, WAIT, RESULT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             first;
    logic [2:0]       cnt_clip;
    logic             q_acc, c_acc;

    assign sl_dist = c_dist;
    assign sl_idx  = c_idx;
    assign busy    = (state != IDLE);
    assign r_valid = (state == RESULT);
    assign q_acc   = q_valid && q_ready;
    assign c_acc   = c_valid && c_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // q_ready is gated by rst because IDLE is also the state held during reset
    always_comb begin
        state_nxt  = state;
        q_ready    = 1'b0;
        c_ready    = 1'b0;
        sl_insert  = 1'b0;
        sl_restart = 1'b0;
        sl_last    = 1'b0;
        unique case (state)
            IDLE: begin
                q_ready = !rst;
                if (q_valid && !rst)
                    state_nxt = (q_num_cand != '0) ? STREAM : EMPTY;
            end
            STREAM: begin
                c_ready = 1'b1;
                if (c_valid) begin
                    sl_insert  = 1'b1;
                    sl_restart = first;
                    sl_last    = (remaining == CNT_W'(1));
                    if (remaining == CNT_W'(1)) state_nxt = WAIT;
                end
            end
            EMPTY: begin
                sl_restart = 1'b1;
                state_nxt  = RESULT;
            end
            WAIT: begin
                if (sl_valid_out) state_nxt = RESULT;
            end
            RESULT: begin
                if (r_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            first     <= 1'b0;
            cnt_clip  <= '0;
            r_id      <= '0;
            r_count   <= '0;
            r_dist_0  <= '0;
            r_dist_1  <= '0;
            r_dist_2  <= '0;
            r_dist_3  <= '0;
            r_idx_0   <= '0;
            r_idx_1   <= '0;
            r_idx_2   <= '0;
            r_idx_3   <= '0;
        end else begin
            if (state == IDLE && q_acc) begin
                r_id      <= q_id;
                remaining <= q_num_cand;
                first     <= 1'b1;
                cnt_clip  <= (q_num_cand > CNT_W'(4)) ? 3'd4 : q_num_cand[2:0];
            end
            if (state == STREAM && c_acc) begin
                first     <= 1'b0;
                remaining <= (remaining == '0) ? '0 : remaining - CNT_W'(1);
            end
            if (state == EMPTY) begin
                first   <= 1'b0;
                r_count <= '0;
            end
            if (state == WAIT && sl_valid_out) begin
                r_count  <= cnt_clip;
                r_dist_0 <= sl_dist_0;
                r_dist_1 <= sl_dist_1;
                r_dist_2 <= sl_dist_2;
                r_dist_3 <= sl_dist_3;
                r_idx_0  <= sl_idx_0;
                r_idx_1  <= sl_idx_1;
                r_idx_2  <= sl_idx_2;
                r_idx_3  <= sl_idx_3;
            end
        end
    end

endmodule

// File: tb/tb_query_sort_ctrl.sv
// Bench for query_sort_ctrl: a behavioural 4-deep sorted-list stub plus rank-based
// expectations of the nearest entries for directed and random queries.
module tb_query_sort_ctrl;
    localparam int DW = 25;
    localparam int IW = 15;
    localparam int CW = 10;
    localparam int QW = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          q_valid, q_ready, c_valid, c_ready;
    logic [QW-1:0] q_id;
    logic [CW-1:0] q_num_cand;
    logic [DW-1:0] c_dist, sl_dist;
    logic [IW-1:0] c_idx, sl_idx;
    logic          sl_insert, sl_restart, sl_last;
    logic          stub_valid = 1'b0;
    logic [DW-1:0] stub_d [4];
    logic [IW-1:0] stub_i [4];
    logic          r_valid, r_ready, busy;
    logic [QW-1:0] r_id;
    logic [2:0]    r_count;
    logic [DW-1:0] r_d [4];
    logic [IW-1:0] r_i [4];

    always #5 clk = ~clk;

    query_sort_ctrl #(.DIST_W(DW), .IDX_W(IW), .CNT_W(CW), .QID_W(QW)) dut (
        .clk(clk), .rst(rst),
        .q_valid(q_valid), .q_ready(q_ready), .q_id(q_id), .q_num_cand(q_num_cand),
        .c_valid(c_valid), .c_ready(c_ready), .c_dist(c_dist), .c_idx(c_idx),
        .sl_insert(sl_insert), .sl_restart(sl_restart), .sl_last(sl_last),
        .sl_dist(sl_dist), .sl_idx(sl_idx), .sl_valid_out(stub_valid),
        .sl_dist_0(stub_d[0]), .sl_dist_1(stub_d[1]), .sl_dist_2(stub_d[2]), .sl_dist_3(stub_d[3]),
        .sl_idx_0(stub_i[0]), .sl_idx_1(stub_i[1]), .sl_idx_2(stub_i[2]), .sl_idx_3(stub_i[3]),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_count(r_count),
        .r_dist_0(r_d[0]), .r_dist_1(r_d[1]), .r_dist_2(r_d[2]), .r_dist_3(r_d[3]),
        .r_idx_0(r_i[0]), .r_idx_1(r_i[1]), .r_idx_2(r_i[2]), .r_idx_3(r_i[3]),
        .busy(busy)
    );

    // Sorted-list stub: keeps the 4 smallest distances, reports one cycle after the last insert
    logic [DW-1:0] sd [4];
    logic [IW-1:0] si [4];
    int            scnt = 0;
    bit            stub_mute = 1'b0;
    int            n_ins = 0, n_rst = 0, n_last = 0;

    always @(posedge clk) begin : stub
        int p;
        if (sl_restart) scnt = 0;
        if (sl_insert) begin
            p = 0;
            while (p < scnt && sd[p] <= sl_dist) p++;
            if (p < 4) begin
                for (int k = 3; k > p; k--) begin
                    sd[k] = sd[k-1];
                    si[k] = si[k-1];
                end
                sd[p] = sl_dist;
                si[p] = sl_idx;
                if (scnt < 4) scnt++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            stub_d[k] <= (k < scnt) ? sd[k] : '1;
            stub_i[k] <= (k < scnt) ? si[k] : '0;
        end
        stub_valid <= sl_insert && sl_last && !stub_mute;
        if (sl_insert)  n_ins++;
        if (sl_restart) n_rst++;
        if (sl_last)    n_last++;
    end

    int            checks = 0, failures = 0;
    logic [DW-1:0] td [16];
    logic [IW-1:0] ti [16];
    logic [DW-1:0] ed [4];
    logic [IW-1:0] ei [4];
    int            e_cnt;
    logic [QW-1:0] e_id;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_r_valid"}, 64'(r_valid), 64'(1));
        chk({tag, "_r_count"}, 64'(r_count), 64'(e_cnt));
        chk({tag, "_r_id"}, 64'(r_id), 64'(e_id));
        for (int k = 0; k < 4; k++) begin
            if (k < e_cnt) begin
                chk($sformatf("%s_r_dist_%0d", tag, k), 64'(r_d[k]), 64'(ed[k]));
                chk($sformatf("%s_r_idx_%0d", tag, k), 64'(r_i[k]), 64'(ei[k]));
            end
        end
    endtask

    task automatic gen_unique(input int n);
        bit dup;
        for (int j = 0; j < n; j++) begin
            do begin
                td[j] = DW'($urandom_range(0, 33554431));
                dup = 1'b0;
                for (int m = 0; m < j; m++) if (td[m] == td[j]) dup = 1'b1;
            end while (dup);
            ti[j] = IW'($urandom);
        end
    endtask

    // Called from an IDLE cycle (after its negedge); ends one cycle into the following IDLE.
    task automatic run_query(input string tag, input logic [QW-1:0] qid, input int n,
                             input int gmax, input int hold, input bit chain,
                             input logic [QW-1:0] nid, input int nn);
        int ins0, rs0, la0, rank, g;
        e_cnt = (n > 4) ? 4 : n;
        e_id  = qid;
        for (int j = 0; j < n; j++) begin
            rank = 0;
            for (int m = 0; m < n; m++) if (td[m] < td[j]) rank++;
            if (rank < 4) begin
                ed[rank] = td[j];
                ei[rank] = ti[j];
            end
        end
        q_valid = 1'b1; q_id = qid; q_num_cand = CW'(n);
        #1;
        chk({tag, "_q_ready"}, 64'(q_ready), 64'(1));
        ins0 = n_ins; rs0 = n_rst; la0 = n_last;
        @(negedge clk);
        q_valid = 1'b0; q_id = QW'($urandom); q_num_cand = CW'($urandom);
        if (n == 0) begin
            #1;
            chk({tag, "_empty_restart"}, 64'(sl_restart), 64'(1));
            chk({tag, "_empty_insert"}, 64'(sl_insert), 64'(0));
            chk({tag, "_empty_c_ready"}, 64'(c_ready), 64'(0));
            @(negedge clk);
        end else begin
            for (int i = 0; i < n; i++) begin
                g = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
                repeat (g) begin
                    c_valid = 1'b0; c_dist = DW'($urandom);
                    #1;
                    chk({tag, "_gap_insert"}, 64'(sl_insert), 64'(0));
                    chk({tag, "_gap_c_ready"}, 64'(c_ready), 64'(1));
                    @(negedge clk);
                end
                c_valid = 1'b1; c_dist = td[i]; c_idx = ti[i];
                #1;
                chk({tag, "_insert"}, 64'(sl_insert), 64'(1));
                chk({tag, "_restart"}, 64'(sl_restart), 64'(i == 0));
                chk({tag, "_last"}, 64'(sl_last), 64'(i == n - 1));
                chk({tag, "_sl_dist"}, 64'(sl_dist), 64'(td[i]));
                chk({tag, "_sl_idx"}, 64'(sl_idx), 64'(ti[i]));
                @(negedge clk);
            end
            c_valid = 1'b1; c_dist = DW'($urandom);
            #1;
            chk({tag, "_wait_c_ready"}, 64'(c_ready), 64'(0));
            chk({tag, "_wait_insert"}, 64'(sl_insert), 64'(0));
            chk({tag, "_t1_r_valid"}, 64'(r_valid), 64'(0));
            @(negedge clk);
            c_valid = 1'b0;
        end
        #1;
        chk_result(tag);
        chk({tag, "_n_insert"}, 64'(n_ins - ins0), 64'(n));
        chk({tag, "_n_restart"}, 64'(n_rst - rs0), 64'(1));
        chk({tag, "_n_last"}, 64'(n_last - la0), 64'(n > 0));
        repeat (hold) begin
            r_ready = 1'b0;
            @(negedge clk);
            #1;
            chk_result({tag, "_hold"});
            chk({tag, "_hold_q_ready"}, 64'(q_ready), 64'(0));
        end
        r_ready = 1'b1;
        if (chain) begin
            q_valid = 1'b1; q_id = nid; q_num_cand = CW'(nn);
        end
        #1;
        chk({tag, "_result_q_ready"}, 64'(q_ready), 64'(0));
        @(negedge clk);
        r_ready = 1'b0;
        #1;
        chk({tag, "_done_r_valid"}, 64'(r_valid), 64'(0));
        chk({tag, "_done_q_ready"}, 64'(q_ready), 64'(1));
        chk({tag, "_done_busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        q_valid = 1'b0; q_id = '0; q_num_cand = '0;
        c_valid = 1'b0; c_dist = '0; c_idx = '0; r_ready = 1'b0;

        @(negedge clk);
        #1;
        chk("rst_q_ready", 64'(q_ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_r_valid", 64'(r_valid), 64'(0));
        chk("rst_r_count", 64'(r_count), 64'(0));
        chk("rst_r_id", 64'(r_id), 64'(0));
        chk("rst_r_dist_0", 64'(r_d[0]), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_q_ready", 64'(q_ready), 64'(1));

        td[0] = 40; td[1] = 10; td[2] = 30; td[3] = 20; td[4] = 50; td[5] = 5;
        for (int j = 0; j < 6; j++) ti[j] = IW'(100 + j);
        run_query("six", 11'd5, 6, 0, 0, 1'b0, '0, 0);

        td[0] = 7; ti[0] = 15'h1234;
        run_query("one", 11'd77, 1, 0, 1, 1'b0, '0, 0);

        run_query("zero", 11'd3, 0, 0, 0, 1'b0, '0, 0);

        gen_unique(3);
        run_query("gaps", 11'd200, 3, 3, 10, 1'b0, '0, 0);

        // Abandon a query midway; the result of the next query must hold only its own entries
        gen_unique(4);
        q_valid = 1'b1; q_id = 11'd9; q_num_cand = CW'(4);
        @(negedge clk);
        q_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c_valid = 1'b1; c_dist = td[i]; c_idx = ti[i];
            @(negedge clk);
        end
        c_dist = td[2]; rst = 1'b1;
        #1;
        chk("midrst_q_ready", 64'(q_ready), 64'(0));
        chk("midrst_c_ready", 64'(c_ready), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_insert", 64'(sl_insert), 64'(0));
        chk("midrst_restart", 64'(sl_restart), 64'(0));
        chk("midrst_last", 64'(sl_last), 64'(0));
        chk("midrst_r_valid", 64'(r_valid), 64'(0));
        chk("midrst_r_id", 64'(r_id), 64'(0));
        chk("midrst_r_count", 64'(r_count), 64'(0));
        c_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_q_ready", 64'(q_ready), 64'(1));
        td[0] = 900; td[1] = 800; ti[0] = 15'd1; ti[1] = 15'd2;
        run_query("after_rst", 11'd10, 2, 0, 0, 1'b0, '0, 0);

        // r_ready in the rising cycle with the next query already waiting
        td[0] = 3; td[1] = 1; ti[0] = 15'd30; ti[1] = 15'd10;
        run_query("chain_a", 11'd21, 2, 0, 0, 1'b1, 11'd22, 1);
        td[0] = 44; ti[0] = 15'd44;
        run_query("chain_b", 11'd22, 1, 0, 0, 1'b0, '0, 0);

        // Without sl_valid_out the controller waits forever
        stub_mute = 1'b1;
        q_valid = 1'b1; q_id = 11'd50; q_num_cand = CW'(1);
        @(negedge clk);
        q_valid = 1'b0; c_valid = 1'b1; c_dist = 25'd99;
        @(negedge clk);
        c_valid = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        chk("stall_busy", 64'(busy), 64'(1));
        chk("stall_r_valid", 64'(r_valid), 64'(0));
        chk("stall_q_ready", 64'(q_ready), 64'(0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; stub_mute = 1'b0;
        #1;

        for (int t = 0; t < 8; t++) begin
            int n;
            n = int'($urandom_range(0, 8));
            gen_unique(n);
            run_query($sformatf("rand%0d", t), QW'($urandom), n, 2,
                      int'($urandom_range(0, 3)), 1'b0, '0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
